seq_display: RTL and testbench

- Downstream consumer of the 6-bit per-second launch sequence address `seq`.
- Runs on the 1 kHz scan clock and resynchronises `seq` into that domain.
- Decodes the current phase (idle, ready, countdown, launch/flight) and drives a 2-digit multiplexed 7-segment display, a launch LED and a buzzer.

---
 rtl/seq_display.sv | 204 ++++++++++++++++++++
 tb/tb_seq_display.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/seq_display.sv
// seq_display: resynchronises the 6-bit launch sequence address into the
// 1 kHz scan domain. It decodes idle / ready / countdown / launch phases from
// the accepted value and drives:
//   - a 2-digit multiplexed 7-segment display,
//   - a launch LED,
//   - a tick / launch buzzer.
// Ports:
//   clk_1k  in   scan clock, all state on posedge
//   rst     in   asynchronous reset, active-low
//   seq     in   [5:0] sequence address, asynchronous to clk_1k
//   seg     out  [6:0] segments a..g, active-high, bit0 = a
//   sel     out  [1:0] digit selects, active-low, sel[1] = tens, sel[0] = units
//   led     out  launch indicator
//   buzz    out  buzzer drive
module seq_display #(
    parameter int unsigned SCAN_DIV = 4,
    parameter int unsigned BEEP_LEN = 100
) (
    input  logic       clk_1k,
    input  logic       rst,
    input  logic [5:0] seq,
    output logic [6:0] seg,
    output logic [1:0] sel,
    output logic       led,
    output logic       buzz
);

    localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned BEEP_W = $clog2(BEEP_LEN + 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BEEP_W-1:0] BEEP_INIT = BEEP_W'(BEEP_LEN);

    localparam logic [6:0] PAT_R = 7'b1010000;
    localparam logic [6:0] PAT_D = 7'b1011110;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_READY,
        PH_COUNT,
        PH_LAUNCH
    } phase_t;

    // Standard 7-segment font, bit0 = a.
    function automatic logic [6:0] font(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'b0111111;
            4'd1:    p = 7'b0000110;
            4'd2:    p = 7'b1011011;
            4'd3:    p = 7'b1001111;
            4'd4:    p = 7'b1100110;
            4'd5:    p = 7'b1101101;
            4'd6:    p = 7'b1111101;
            4'd7:    p = 7'b0000111;
            4'd8:    p = 7'b1111111;
            4'd9:    p = 7'b1101111;
            default: p = 7'b0000000;
        endcase
        return p;
    endfunction

    logic [5:0]        s1;
    logic [5:0]        s2;
    logic [5:0]        cur;
    logic [SCAN_W-1:0] scan_cnt;
    logic              ptr;
    logic [BEEP_W-1:0] beep_cnt;

    logic [5:0]        cur_nx;
    logic              accept;
    logic              load;
    phase_t            phase;
    logic [4:0]        value;
    logic [1:0]        tens;
    logic [3:0]        units;
    logic [6:0]        tens_pat;
    logic [6:0]        units_pat;
    logic [SCAN_W-1:0] scan_nx;
    logic              ptr_nx;
    logic [BEEP_W-1:0] beep_nx;
    logic [6:0]        seg_nx;
    logic [1:0]        sel_nx;
    logic              led_nx;
    logic              buzz_nx;

    // Capture acceptance and new-countdown-value detection.
    // s2 is accepted once the synchroniser holds the same value in both stages,
    // i.e. two equal consecutive samples; 1-cycle glitches never satisfy this.
    always_comb begin
        accept = 1'b0;
        cur_nx = cur;
        load   = 1'b0;
        if (s1 == s2) begin
            accept = 1'b1;
            cur_nx = s2;
        end
        load = accept && (s2 != cur) && (s2 >= 6'd2) && (s2 <= 6'd31);
    end

    // Phase and decimal decode of the value being accepted this edge.
    always_comb begin
        phase = PH_COUNT;
        value = 5'd0;
        tens  = 2'd0;
        units = 4'd0;
        if (cur_nx == 6'd0) begin
            phase = PH_IDLE;
        end else if (cur_nx == 6'd1) begin
            phase = PH_READY;
        end else if (cur_nx[5]) begin
            phase = PH_LAUNCH;
        end
        value = (phase == PH_LAUNCH) ? cur_nx[4:0] : 5'(6'd32 - cur_nx);
        if (value >= 5'd30) begin
            tens  = 2'd3;
            units = 4'(value - 5'd30);
        end else if (value >= 5'd20) begin
            tens  = 2'd2;
            units = 4'(value - 5'd20);
        end else if (value >= 5'd10) begin
            tens  = 2'd1;
            units = 4'(value - 5'd10);
        end else begin
            tens  = 2'd0;
            units = 4'(value);
        end
    end

    // Digit patterns, scan sequencing, beep and registered output values.
    always_comb begin
        tens_pat  = 7'd0;
        units_pat = 7'd0;
        scan_nx   = scan_cnt + SCAN_W'(1);
        ptr_nx    = ptr;
        beep_nx   = '0;
        buzz_nx   = 1'b0;

        case (phase)
            PH_IDLE: begin
                tens_pat  = 7'd0;
                units_pat = 7'd0;
            end
            PH_READY: begin
                tens_pat  = PAT_R;
                units_pat = PAT_D;
            end
            default: begin
                tens_pat  = font({2'b00, tens});
                units_pat = font(units);
            end
        endcase

        if (scan_cnt == SCAN_LAST) begin
            scan_nx = '0;
            ptr_nx  = ~ptr;
        end

        // Launch phase carries no tick beeps; a pending tick is dropped there.
        if (load) begin
            beep_nx = BEEP_INIT;
        end else if (cur_nx[5]) begin
            beep_nx = '0;
        end else if (beep_cnt != '0) begin
            beep_nx = beep_cnt - BEEP_W'(1);
        end

        if ((cur_nx == 6'd32) || (beep_nx != '0)) begin
            buzz_nx = ~buzz;
        end

        // Select follows the current pointer so each digit is held SCAN_DIV cycles.
        seg_nx = ptr ? tens_pat : units_pat;
        sel_nx = ptr ? 2'b01 : 2'b10;
        led_nx = cur_nx[5];
    end

    // State and output registers.
    always_ff @(posedge clk_1k or negedge rst) begin
        if (!rst) begin
            s1       <= '0;
            s2       <= '0;
            cur      <= '0;
            scan_cnt <= '0;
            ptr      <= 1'b0;
            beep_cnt <= '0;
            seg      <= 7'd0;
            sel      <= 2'b11;
            led      <= 1'b0;
            buzz     <= 1'b0;
        end else begin
            s1       <= seq;
            s2       <= s1;
            cur      <= cur_nx;
            scan_cnt <= scan_nx;
            ptr      <= ptr_nx;
            beep_cnt <= beep_nx;
            seg      <= seg_nx;
            sel      <= sel_nx;
            led      <= led_nx;
            buzz     <= buzz_nx;
        end
    end

endmodule

// File: tb/tb_seq_display.sv
// Scoreboard bench for seq_display: a behavioural model pushes the expected
// outputs after every clock edge; a monitor pops and compares one entry per edge.
module tb_seq_display;

    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned BEEP_LEN = 100;

    logic       clk_1k = 1'b0;
    logic       rst    = 1'b0;
    logic [5:0] seq    = 6'd20;
    logic [6:0] seg;
    logic [1:0] sel;
    logic       led;
    logic       buzz;

    always #5 clk_1k = ~clk_1k;

    seq_display #(.SCAN_DIV(SCAN_DIV), .BEEP_LEN(BEEP_LEN)) dut (
        .clk_1k (clk_1k),
        .rst    (rst),
        .seq    (seq),
        .seg    (seg),
        .sel    (sel),
        .led    (led),
        .buzz   (buzz)
    );

    typedef struct packed {
        logic [6:0] seg;
        logic [1:0] sel;
        logic       led;
        logic       buzz;
    } obs_t;

    obs_t exp_q[$];
    int   passed = 0;
    int   total  = 0;

    logic [6:0] font [10];
    initial begin
        font[0] = 7'h3F; font[1] = 7'h06; font[2] = 7'h5B; font[3] = 7'h4F;
        font[4] = 7'h66; font[5] = 7'h6D; font[6] = 7'h7D; font[7] = 7'h07;
        font[8] = 7'h7F; font[9] = 7'h6F;
    end

    // Expected {tens, units} patterns for an accepted sequence address.
    function automatic logic [13:0] digits(input int c);
        int v;
        if (c == 0) return 14'd0;
        if (c == 1) return {7'b1010000, 7'b1011110};
        v = (c < 32) ? (32 - c) : (c - 32);
        return {font[v / 10], font[v % 10]};
    endfunction

    // Reference model: a seq value is accepted once it was sampled on two
    // consecutive edges, becoming visible on the following edge.
    int   m_cur, m_prev1, m_prev2, m_beep, m_n;
    logic m_buzz;
    always @(posedge clk_1k) begin
        obs_t        e;
        logic [13:0] d;
        logic        p;
        if (!rst) begin
            m_cur = 0; m_prev1 = 0; m_prev2 = 0; m_beep = 0; m_n = 0; m_buzz = 1'b0;
            e = '{seg: 7'd0, sel: 2'b11, led: 1'b0, buzz: 1'b0};
        end else begin
            bit changed;
            m_n++;
            changed = (m_prev1 == m_prev2) && (m_prev2 != m_cur);
            if (changed) m_cur = m_prev2;
            if (changed && m_cur >= 2 && m_cur <= 31) m_beep = BEEP_LEN;
            else if (m_cur >= 32) m_beep = 0;
            else if (m_beep > 0) m_beep--;
            m_buzz = (m_cur == 32 || m_beep > 0) ? ~m_buzz : 1'b0;
            m_prev2 = m_prev1;
            m_prev1 = int'(seq);
            p = (((m_n - 1) / SCAN_DIV) % 2) == 1;
            d = digits(m_cur);
            e.seg  = p ? d[13:7] : d[6:0];
            e.sel  = p ? 2'b01 : 2'b10;
            e.led  = (m_cur >= 32);
            e.buzz = m_buzz;
        end
        exp_q.push_back(e);
    end

    // Monitor: compare DUT outputs shortly after each edge.
    always @(posedge clk_1k) begin
        obs_t e;
        obs_t a;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{seg: seg, sel: sel, led: led, buzz: buzz};
            total++;
            if (a === e) passed++;
            else $display("FAIL outputs t=%0t got seg=%b sel=%b led=%b buzz=%b want seg=%b sel=%b led=%b buzz=%b",
                          $time, a.seg, a.sel, a.led, a.buzz, e.seg, e.sel, e.led, e.buzz);
        end
    end

    task automatic hold(input int v, input int cyc);
        seq = 6'(v);
        repeat (cyc) @(negedge clk_1k);
    endtask

    // Asynchronous reset pulse; outputs must clear before any clock edge.
    task automatic pulse_reset(input int cyc);
        rst = 1'b0;
        #1;
        total++;
        if (seg === 7'd0 && sel === 2'b11 && led === 1'b0 && buzz === 1'b0) passed++;
        else $display("FAIL async_reset t=%0t got seg=%b sel=%b led=%b buzz=%b want 0000000/11/0/0",
                      $time, seg, sel, led, buzz);
        @(negedge clk_1k);
        repeat (cyc) @(negedge clk_1k);
        rst = 1'b1;
    endtask

    initial begin
        @(negedge clk_1k);
        hold(20, 10);
        rst = 1'b1;
        hold(20, 30);
        hold(1, 40);
        hold(2, 250);
        hold(3, 250);
        hold(32, 300);
        hold(33, 250);
        hold(10, 250);
        hold(45, 1);
        hold(10, 250);
        hold(63, 250);
        hold(0, 250);
        hold(5, 50);
        pulse_reset(3);
        hold(5, 250);
        hold(1, 30);
        hold(2, 250);
        hold(33, 100);
        hold(2, 250);

        for (int i = 0; i < 200; i++) begin
            int r;
            int len;
            r = int'($urandom_range(0, 9));
            if (r == 0)      len = 1;
            else if (r == 1) len = 2;
            else if (r == 2) len = int'($urandom_range(3, 10));
            else             len = int'($urandom_range(20, 260));
            if ($urandom_range(0, 19) == 0) pulse_reset(int'($urandom_range(0, 3)));
            hold(int'($urandom_range(0, 63)), len);
        end

        repeat (4) @(negedge clk_1k);
        total++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
